// File: rtl/bp_next_pc_pkg.sv
// Shared types and constants for the branch-prediction next-PC stage.
package bp_next_pc_pkg;

  localparam int REG_W = 32;

  // Instruction class delivered by pre-decode.
  typedef enum logic [1:0] {
    TYPE_NUL  = 2'b00,
    TYPE_CALL = 2'b01,
    TYPE_RET  = 2'b10,
    TYPE_PCR  = 2'b11
  } inst_type_e;

  // BHT counters come out of reset weakly not-taken.
  localparam logic [1:0] BHT_RST_VAL = 2'b01;

  // Saturating 2-bit counter step.
  function automatic logic [1:0] sat_cnt(input logic [1:0] cnt, input logic up);
    logic [1:0] res;
    res = cnt;
    if (up && cnt != 2'b11) res = cnt + 2'b01;
    else if (!up && cnt != 2'b00) res = cnt - 2'b01;
    return res;
  endfunction

endpackage

// File: rtl/bp_next_pc_if.sv
// Lookup, training and prediction signals of the next-PC predictor.
interface bp_next_pc_if;
  import bp_next_pc_pkg::*;

  logic             pd_valid;
  logic [REG_W-1:0] pd_pc;
  logic [1:0]       pd_inst_type;
  logic [REG_W-1:0] pd_inst_offset;
  logic             pd_link;
  logic             flush;
  logic             upd_valid;
  logic [REG_W-1:0] upd_pc;
  logic             upd_taken;
  logic             pred_valid;
  logic             pred_taken;
  logic [REG_W-1:0] pred_target;
  logic             ras_empty;

  // Fetch / EX side drives lookups and training.
  modport master (
    output pd_valid, pd_pc, pd_inst_type, pd_inst_offset, pd_link, flush,
    output upd_valid, upd_pc, upd_taken,
    input  pred_valid, pred_taken, pred_target, ras_empty
  );

  // Predictor side.
  modport slave (
    input  pd_valid, pd_pc, pd_inst_type, pd_inst_offset, pd_link, flush,
    input  upd_valid, upd_pc, upd_taken,
    output pred_valid, pred_taken, pred_target, ras_empty
  );
endinterface

// File: rtl/bp_next_pc_ras_stack.sv
// Circular return address stack; a push when full overwrites the oldest entry.
module ras_stack
  import bp_next_pc_pkg::*;
#(
  parameter int RAS_DEPTH = 8,
  parameter int RAS_PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [REG_W-1:0] push_data,
  output logic [REG_W-1:0] top_data,
  output logic             empty
);

  localparam logic [RAS_PTR_W-1:0] PTR_ONE  = RAS_PTR_W'(1);
  localparam logic [RAS_PTR_W:0]   CNT_FULL = (RAS_PTR_W+1)'(RAS_DEPTH);
  localparam logic [RAS_PTR_W:0]   CNT_ONE  = (RAS_PTR_W+1)'(1);

  // ptr_q is the next free slot; the top entry sits one below it.
  logic [REG_W-1:0]     mem_q [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] ptr_q, ptr_d, top_ptr, wr_idx;
  logic [RAS_PTR_W:0]   cnt_q, cnt_d;
  logic                 wr_en, pop_eff;

  assign top_ptr  = ptr_q - PTR_ONE;
  assign pop_eff  = pop && (cnt_q != '0);
  assign top_data = mem_q[top_ptr];
  assign empty    = (cnt_q == '0);

  // Pointer/count next state; simultaneous pop+push replaces the top in place.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (pop_eff && push) begin
      wr_en  = 1'b1;
      wr_idx = top_ptr;
    end else if (pop_eff) begin
      ptr_d = top_ptr;
      cnt_d = cnt_q - CNT_ONE;
    end else if (push) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + PTR_ONE;
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; stale contents are harmless because count gates reads.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/bp_next_pc.sv
// Next-PC predictor: BHT of 2-bit counters plus RAS, one-cycle registered prediction.
module bp_next_pc
  import bp_next_pc_pkg::*;
#(
  parameter int BHT_IDX_W = 6,
  parameter int RAS_DEPTH = 8,
  parameter int RAS_PTR_W = 3
) (
  input  logic         clk,
  input  logic         rst,
  bp_next_pc_if.slave  bus
);

  localparam int BHT_N = 1 << BHT_IDX_W;

  logic [1:0]           bht_q [BHT_N];
  logic [BHT_IDX_W-1:0] lk_idx, upd_idx;
  logic [REG_W-1:0]     pc4, pc8, ras_top, target_d;
  logic                 lookup, taken_d, ras_push, ras_pop, ras_is_empty;
  inst_type_e           itype;
  logic                 pred_valid_q, pred_taken_q;
  logic [REG_W-1:0]     pred_target_q;
  logic                 unused_upd_bits;

  assign unused_upd_bits = ^{bus.upd_pc[REG_W-1:BHT_IDX_W+2], bus.upd_pc[1:0]};

  assign lookup  = bus.pd_valid && !bus.flush;
  assign itype   = inst_type_e'(bus.pd_inst_type);
  assign lk_idx  = bus.pd_pc[BHT_IDX_W+1:2];
  assign upd_idx = bus.upd_pc[BHT_IDX_W+1:2];
  assign pc4     = bus.pd_pc + 32'd4;
  assign pc8     = bus.pd_pc + 32'd8;

  // Return address is pushed past the delay slot; RET pops.
  assign ras_push = lookup && ((itype == TYPE_CALL && bus.pd_link) || itype == TYPE_PCR);
  assign ras_pop  = lookup && (itype == TYPE_RET);

  ras_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .RAS_PTR_W (RAS_PTR_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc8),
    .top_data  (ras_top),
    .empty     (ras_is_empty)
  );

  // Direction and target selection by instruction class.
  always_comb begin
    taken_d  = 1'b0;
    target_d = pc4;
    case (itype)
      TYPE_NUL: begin
        taken_d  = 1'b0;
        target_d = pc4;
      end
      TYPE_CALL: begin
        taken_d  = 1'b1;
        target_d = {pc4[31:28], bus.pd_inst_offset[27:0]};
      end
      TYPE_PCR: begin
        taken_d  = bht_q[lk_idx][1];
        target_d = pc4 + bus.pd_inst_offset;
      end
      TYPE_RET: begin
        taken_d  = !ras_is_empty;
        target_d = ras_is_empty ? pc4 : ras_top;
      end
    endcase
  end

  // BHT training; a lookup in the same cycle has already read the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= BHT_RST_VAL;
    end else if (bus.upd_valid) begin
      bht_q[upd_idx] <= sat_cnt(bht_q[upd_idx], bus.upd_taken);
    end
  end

  // Prediction output register; target holds across idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      pred_valid_q <= lookup;
      pred_taken_q <= lookup && taken_d;
      if (lookup) pred_target_q <= target_d;
    end
  end

  assign bus.pred_valid  = pred_valid_q;
  assign bus.pred_taken  = pred_taken_q;
  assign bus.pred_target = pred_target_q;
  assign bus.ras_empty   = ras_is_empty;

endmodule

// File: tb/tb_bp_next_pc.sv
// Bench for bp_next_pc: directed scenarios plus random traffic against a queue/array model.
module tb_bp_next_pc;
  import bp_next_pc_pkg::*;

  localparam int BHT_IDX_W = 6;
  localparam int RAS_DEPTH = 8;
  localparam int RAS_PTR_W = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bp_next_pc_if bus ();

  bp_next_pc #(
    .BHT_IDX_W (BHT_IDX_W),
    .RAS_DEPTH (RAS_DEPTH),
    .RAS_PTR_W (RAS_PTR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: counters as integers 0..3, RAS as a bounded queue.
  int          bht_m [1 << BHT_IDX_W];
  logic [31:0] ras_m [$];
  logic        exp_valid, exp_taken;
  logic [31:0] exp_target;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[BHT_IDX_W+1:2]);
  endfunction

  task automatic model_reset();
    foreach (bht_m[i]) bht_m[i] = 1;
    ras_m.delete();
    exp_valid  = 1'b0;
    exp_taken  = 1'b0;
    exp_target = 32'h0;
  endtask

  task automatic ras_push_m(input logic [31:0] d);
    ras_m.push_back(d);
    if (ras_m.size() > RAS_DEPTH) void'(ras_m.pop_front());
  endtask

  // Drive one cycle, advance the model, then check all outputs after the edge.
  task automatic cyc(input logic r, input logic v, input logic [31:0] pc, input logic [1:0] ty,
                     input logic [31:0] off, input logic lk, input logic fl,
                     input logic uv, input logic [31:0] upc, input logic ut);
    logic [31:0] pc4;
    rst                = r;
    bus.pd_valid       = v;
    bus.pd_pc          = pc;
    bus.pd_inst_type   = ty;
    bus.pd_inst_offset = off;
    bus.pd_link        = lk;
    bus.flush          = fl;
    bus.upd_valid      = uv;
    bus.upd_pc         = upc;
    bus.upd_taken      = ut;
    pc4 = pc + 32'd4;
    if (r) begin
      model_reset();
    end else begin
      if (v && !fl) begin
        exp_valid = 1'b1;
        case (ty)
          TYPE_NUL: begin
            exp_taken  = 1'b0;
            exp_target = pc4;
          end
          TYPE_CALL: begin
            exp_taken  = 1'b1;
            exp_target = {pc4[31:28], off[27:0]};
            if (lk) ras_push_m(pc + 32'd8);
          end
          TYPE_PCR: begin
            exp_taken  = (bht_m[idx_of(pc)] >= 2);
            exp_target = pc4 + off;
            ras_push_m(pc + 32'd8);
          end
          default: begin
            if (ras_m.size() > 0) begin
              exp_taken  = 1'b1;
              exp_target = ras_m.pop_back();
            end else begin
              exp_taken  = 1'b0;
              exp_target = pc4;
            end
          end
        endcase
      end else begin
        exp_valid = 1'b0;
        exp_taken = 1'b0;
      end
      if (uv) begin
        if (ut) bht_m[idx_of(upc)] = (bht_m[idx_of(upc)] == 3) ? 3 : bht_m[idx_of(upc)] + 1;
        else    bht_m[idx_of(upc)] = (bht_m[idx_of(upc)] == 0) ? 0 : bht_m[idx_of(upc)] - 1;
      end
    end
    @(posedge clk);
    #1;
    chk("pred_valid", 32'(bus.pred_valid), 32'(exp_valid));
    chk("pred_taken", 32'(bus.pred_taken), 32'(exp_taken));
    chk("pred_target", bus.pred_target, exp_target);
    chk("ras_empty", 32'(bus.ras_empty), 32'(ras_m.size() == 0));
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 32'h0, TYPE_NUL, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic lookup(input logic [31:0] pc, input logic [1:0] ty, input logic [31:0] off,
                        input logic lk);
    cyc(1'b0, 1'b1, pc, ty, off, lk, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic update(input logic [31:0] pc, input logic t);
    cyc(1'b0, 1'b0, 32'h0, TYPE_NUL, 32'h0, 1'b0, 1'b0, 1'b1, pc, t);
  endtask

  initial begin
    do_reset();
    do_reset();
    chk("rst_valid", 32'(bus.pred_valid), 32'd0);
    chk("rst_target", bus.pred_target, 32'h0);
    chk("rst_empty", 32'(bus.ras_empty), 32'd1);

    // PCR lookup with a fresh weakly-not-taken counter.
    lookup(32'h0040_0010, TYPE_PCR, 32'h0000_0020, 1'b0);
    chk("pcr_valid", 32'(bus.pred_valid), 32'd1);
    chk("pcr_taken", 32'(bus.pred_taken), 32'd0);
    chk("pcr_target", bus.pred_target, 32'h0040_0034);

    // Train up to strongly taken, then down to strongly not-taken.
    update(32'h0040_0010, 1'b1);
    update(32'h0040_0010, 1'b1);
    lookup(32'h0040_0010, TYPE_PCR, 32'h0000_0020, 1'b0);
    chk("bht_sat_hi", 32'(bus.pred_taken), 32'd1);
    for (int i = 0; i < 3; i++) update(32'h0040_0010, 1'b0);
    lookup(32'h0040_0010, TYPE_PCR, 32'h0000_0020, 1'b0);
    chk("bht_sat_lo", 32'(bus.pred_taken), 32'd0);

    // JAL then JR.
    do_reset();
    lookup(32'hBFC0_0100, TYPE_CALL, 32'h0000_0400, 1'b1);
    chk("jal_taken", 32'(bus.pred_taken), 32'd1);
    chk("jal_target", bus.pred_target, 32'hB000_0400);
    lookup(32'hBFC0_0200, TYPE_RET, 32'h0, 1'b0);
    chk("jr_taken", 32'(bus.pred_taken), 32'd1);
    chk("jr_target", bus.pred_target, 32'hBFC0_0108);
    chk("jr_empty", 32'(bus.ras_empty), 32'd1);

    // Overflow: nine pushes into eight slots, then nine pops.
    do_reset();
    for (int i = 1; i <= 9; i++) lookup(32'(i * 32'h100), TYPE_CALL, 32'h0000_1000, 1'b1);
    for (int i = 0; i < 9; i++) begin
      lookup(32'h0000_2000, TYPE_RET, 32'h0, 1'b0);
      if (i < 8) begin
        chk("ovf_taken", 32'(bus.pred_taken), 32'd1);
        chk("ovf_target", bus.pred_target, 32'(32'h908 - i * 32'h100));
      end else begin
        chk("ovf_last_taken", 32'(bus.pred_taken), 32'd0);
        chk("ovf_last_target", bus.pred_target, 32'h0000_2004);
      end
    end

    // Lookup and update at the same index in the same cycle.
    do_reset();
    cyc(1'b0, 1'b1, 32'h10, TYPE_PCR, 32'h40, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1);
    chk("same_idx_old", 32'(bus.pred_taken), 32'd0);
    lookup(32'h10, TYPE_PCR, 32'h40, 1'b0);
    chk("same_idx_new", 32'(bus.pred_taken), 32'd1);

    // Flushed linked call leaves no trace.
    do_reset();
    cyc(1'b0, 1'b1, 32'h500, TYPE_CALL, 32'h100, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("flush_valid", 32'(bus.pred_valid), 32'd0);
    chk("flush_empty", 32'(bus.ras_empty), 32'd1);

    // Mid-run reset restores counters and empties the RAS.
    lookup(32'h600, TYPE_CALL, 32'h100, 1'b1);
    lookup(32'h700, TYPE_CALL, 32'h100, 1'b1);
    update(32'h14, 1'b1);
    update(32'h14, 1'b1);
    update(32'h18, 1'b0);
    update(32'h18, 1'b0);
    chk("pre_rst_empty", 32'(bus.ras_empty), 32'd0);
    do_reset();
    chk("post_rst_empty", 32'(bus.ras_empty), 32'd1);
    lookup(32'h14, TYPE_PCR, 32'h8, 1'b0);
    chk("post_rst_idx5", 32'(bus.pred_taken), 32'd0);
    update(32'h18, 1'b1);
    lookup(32'h18, TYPE_PCR, 32'h8, 1'b0);
    chk("post_rst_idx6", 32'(bus.pred_taken), 32'd1);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic        r, v, lk, fl, uv, ut;
      logic [1:0]  ty;
      logic [31:0] pc, off, upc;
      r   = ($urandom_range(0, 99) < 2);
      v   = ($urandom_range(0, 3) != 0);
      pc  = $urandom & 32'hF000_00FC;
      ty  = 2'($urandom_range(0, 3));
      off = $urandom;
      lk  = 1'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 9) == 0);
      uv  = 1'($urandom_range(0, 1));
      upc = $urandom & 32'h0000_00FC;
      ut  = 1'($urandom_range(0, 1));
      cyc(r, v, pc, ty, off, lk, fl, uv, upc, ut);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
